// File: rtl/sha256_msg_padder.sv
// Turns a stream of big-endian 32-bit message words into SHA-256 padded 512-bit blocks (16 words each).
// Optional feature: define SHA256_PADDER_BLKCNT_EN to add the blk_cnt block counter output.
module sha256_msg_padder #(
    parameter int LEN_W = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    input  logic [1:0]  in_nbytes,
    input  logic        in_empty,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_sob,
    output logic        out_eom,
    output logic        busy
`ifdef SHA256_PADDER_BLKCNT_EN
    ,
    output logic [15:0] blk_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MSG,
        S_ONE,
        S_ZERO,
        S_LENH,
        S_LENL
    } state_t;

    state_t            state_reg, state_next;
    logic [3:0]        widx_reg;
    logic [LEN_W-1:0]  bits_reg, bits_next;
    logic              out_valid_reg;
    logic [31:0]       out_data_reg;
    logic              out_sob_reg;
    logic              out_eom_reg;
    logic              out_w15_reg;

    logic              load_en;
    logic              accept_state;
    logic              beat;
    logic [2:0]        beat_bytes;
    logic [63:0]       len64;
    logic              at13;
    logic              emit;
    logic [31:0]       emit_data;
    logic              emit_eom;

    assign load_en      = !out_valid_reg || out_ready;
    assign accept_state = (state_reg == S_IDLE) || (state_reg == S_MSG);
    // Gated with reset so in_ready reads 0 while reset is held.
    assign in_ready     = load_en && accept_state && reset;
    assign beat         = in_valid && in_ready;
    assign len64        = 64'(bits_reg);
    // The length words must occupy 14 and 15, so a pad word at 13 leads straight into them.
    assign at13         = (widx_reg == 4'd13);

    always_comb begin
        beat_bytes = 3'd4;
        if (in_last) begin
            if (in_empty)
                beat_bytes = 3'd0;
            else if (in_nbytes != 2'd0)
                beat_bytes = {1'b0, in_nbytes};
        end
    end

    always_comb begin
        state_next = state_reg;
        bits_next  = bits_reg;
        emit       = 1'b0;
        emit_data  = 32'h0000_0000;
        emit_eom   = 1'b0;
        case (state_reg)
            S_IDLE, S_MSG: begin
                if (beat) begin
                    emit      = 1'b1;
                    bits_next = bits_reg + LEN_W'({beat_bytes, 3'b000});
                    if (!in_last) begin
                        emit_data  = in_data;
                        state_next = S_MSG;
                    end else if (in_empty) begin
                        emit_data  = 32'h8000_0000;
                        state_next = at13 ? S_LENH : S_ZERO;
                    end else begin
                        case (in_nbytes)
                            2'd1:    emit_data = {in_data[31:24], 8'h80, 16'h0000};
                            2'd2:    emit_data = {in_data[31:16], 8'h80, 8'h00};
                            2'd3:    emit_data = {in_data[31:8], 8'h80};
                            default: emit_data = in_data;
                        endcase
                        if (in_nbytes == 2'd0)
                            state_next = S_ONE;
                        else
                            state_next = at13 ? S_LENH : S_ZERO;
                    end
                end
            end
            S_ONE: begin
                if (load_en) begin
                    emit       = 1'b1;
                    emit_data  = 32'h8000_0000;
                    state_next = at13 ? S_LENH : S_ZERO;
                end
            end
            S_ZERO: begin
                if (load_en) begin
                    emit = 1'b1;
                    if (at13)
                        state_next = S_LENH;
                end
            end
            S_LENH: begin
                if (load_en) begin
                    emit       = 1'b1;
                    emit_data  = len64[63:32];
                    state_next = S_LENL;
                end
            end
            S_LENL: begin
                if (load_en) begin
                    emit       = 1'b1;
                    emit_data  = len64[31:0];
                    emit_eom   = 1'b1;
                    bits_next  = '0;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= S_IDLE;
            widx_reg      <= 4'd0;
            bits_reg      <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= 32'h0000_0000;
            out_sob_reg   <= 1'b0;
            out_eom_reg   <= 1'b0;
            out_w15_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            bits_reg  <= bits_next;
            if (load_en) begin
                out_valid_reg <= emit;
                if (emit) begin
                    out_data_reg <= emit_data;
                    out_sob_reg  <= (widx_reg == 4'd0);
                    out_eom_reg  <= emit_eom;
                    out_w15_reg  <= (widx_reg == 4'd15);
                    widx_reg     <= widx_reg + 4'd1;
                end
            end
        end
    end

`ifdef SHA256_PADDER_BLKCNT_EN
    logic [15:0] blk_cnt_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            blk_cnt_reg <= 16'd0;
        else if (out_valid_reg && out_ready && out_w15_reg)
            blk_cnt_reg <= blk_cnt_reg + 16'd1;
    end

    assign blk_cnt = blk_cnt_reg;
`endif

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_sob   = out_sob_reg;
    assign out_eom   = out_eom_reg;
    assign busy      = (state_reg != S_IDLE);

endmodule
